lcd_hd44780_responder: RTL and testbench

Behavioural HD44780-compatible responder for the character-LCD bus driven by the team's LCD controller (`data`, `EN`, `RW`, `RS`). It closes the loop in simulation and on-FPGA self-test: it samples the bus on each `EN` falling edge and decodes instructions and data writes. It maintains the display mode flags, the address counter and an 80-byte DDRAM shadow, and asserts a busy flag for the instruction's execution time.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_en_sync.sv | 37 +++
 rtl/lcd_hd44780_responder.sv | 173 +++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and address helpers for the HD44780 behavioural responder.
package lcd_pkg;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_CLEAR} state_t;

  typedef enum logic [3:0] {
    I_NOP, I_CLEAR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
  } instr_t;

  localparam logic [7:0] BLANK      = 8'h20;
  localparam int         DDRAM_SIZE = 80;

  // Instruction class is chosen by the highest set bit of the opcode.
  function automatic instr_t classify(input logic [7:0] d);
    if (d[7])      return I_DDRAM;
    else if (d[6]) return I_CGRAM;
    else if (d[5]) return I_FUNC;
    else if (d[4]) return I_SHIFT;
    else if (d[3]) return I_DISP;
    else if (d[2]) return I_ENTRY;
    else if (d[1]) return I_HOME;
    else if (d[0]) return I_CLEAR;
    else           return I_NOP;
  endfunction

  // dir=1 steps forward; line ends hop to the other line's start.
  function automatic logic [6:0] wrap_addr(input logic [6:0] a, input logic dir);
    logic [6:0] r;
    if (dir) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] fold_addr(input logic [6:0] a);
    if (a[5:0] < 6'd40) return a;
    return a[6] ? 7'h00 : 7'h40;
  endfunction

  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return (a[6] ? 7'd40 : 7'd0) + {1'b0, a[5:0]};
  endfunction
endpackage

// File: rtl/lcd_en_sync.sv
// Two-flop synchronizer for the LCD enable with a falling-edge strobe;
// rs/rw/data ride matching two-flop delays so they line up with the strobe.
module lcd_en_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic       fall,
  output logic       rsQ,
  output logic       rwQ,
  output logic [7:0] dataQ
);
  logic [2:0]      enSr;
  logic [1:0]      rsSr, rwSr;
  logic [1:0][7:0] dataSr;

  always_ff @(posedge clk) begin
    if (rst) begin
      enSr   <= '0;
      rsSr   <= '0;
      rwSr   <= '0;
      dataSr <= '0;
    end else begin
      enSr   <= {enSr[1:0], en};
      rsSr   <= {rsSr[0], rs};
      rwSr   <= {rwSr[0], rw};
      dataSr <= {dataSr[0], data};
    end
  end

  assign fall  = enSr[2] & ~enSr[1];
  assign rsQ   = rsSr[1];
  assign rwQ   = rwSr[1];
  assign dataQ = dataSr[1];
endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible bus responder: decodes EN-strobed writes, keeps mode flags,
// address counter and DDRAM shadow. Define LCD_RESP_READ_EN for busy/address reads.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       eight_bit,
  output logic       two_line,
  output logic       incr,
  output logic       shift,
  output logic [6:0] addr,
  output logic       char_wr,
  output logic [6:0] char_wr_addr,
  output logic [7:0] char_wr_data,
  input  logic [6:0] mem_raddr,
  output logic [7:0] mem_rdata,
  output logic       overrun
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  state_t          state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic [6:0]      sweep, sweepNext;
  logic            fall, rsQ, rwQ, accept, cgMode;
  logic [7:0]      dataQ;
  instr_t          cls;
  logic            memWe;
  logic [6:0]      memWa, rIdx;
  logic [7:0]      memWd;
  logic [7:0]      mem [DDRAM_SIZE];

  lcd_en_sync uSync (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .rw(rw), .data(data),
    .fall(fall), .rsQ(rsQ), .rwQ(rwQ), .dataQ(dataQ)
  );

  assign busy   = (state != S_IDLE);
  assign cls    = classify(dataQ);
  assign accept = fall & ~rwQ & (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
      sweep <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      sweep <= sweepNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    sweepNext = sweep;
    memWe     = 1'b0;
    memWa     = sweep;
    memWd     = BLANK;
    case (state)
      S_INIT, S_CLEAR: begin
        memWe     = 1'b1;
        sweepNext = sweep + 7'd1;
        if (sweep == 7'(DDRAM_SIZE - 1)) begin
          sweepNext = '0;
          // Clear spends the rest of its budget in EXEC after the sweep.
          stateNext = (state == S_INIT) ? S_IDLE : S_EXEC;
          cntNext   = CW'(CLEAR_CYCLES - DDRAM_SIZE - 1);
        end
      end
      S_EXEC: begin
        if (cnt == '0) stateNext = S_IDLE;
        else           cntNext   = cnt - 1'b1;
      end
      S_IDLE: begin
        if (accept) begin
          stateNext = S_EXEC;
          cntNext   = CW'(CMD_CYCLES - 1);
          if (rsQ) begin
            memWe = ~cgMode;
            memWa = ddram_idx(addr);
            memWd = dataQ;
          end else if (cls == I_CLEAR) begin
            stateNext = S_CLEAR;
            sweepNext = '0;
          end else if (cls == I_HOME) begin
            cntNext = CW'(CLEAR_CYCLES - 1);
          end
        end
      end
      default: stateNext = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      eight_bit    <= 1'b1;
      two_line     <= 1'b0;
      incr         <= 1'b1;
      shift        <= 1'b0;
      addr         <= '0;
      char_wr      <= 1'b0;
      char_wr_addr <= '0;
      char_wr_data <= '0;
      overrun      <= 1'b0;
      cgMode       <= 1'b0;
    end else begin
      char_wr <= 1'b0;
      if (fall && !rwQ && busy) overrun <= 1'b1;
      if (accept) begin
        if (rsQ) begin
          if (!cgMode) begin
            char_wr      <= 1'b1;
            char_wr_addr <= addr;
            char_wr_data <= dataQ;
            addr         <= wrap_addr(addr, incr);
          end
        end else begin
          case (cls)
            I_CLEAR: begin addr <= '0; incr <= 1'b1; end
            I_HOME:  addr <= '0;
            I_ENTRY: begin incr <= dataQ[1]; shift <= dataQ[0]; end
            I_DISP:  begin
              display_on <= dataQ[2];
              cursor_on  <= dataQ[1];
              blink_on   <= dataQ[0];
            end
            I_SHIFT: if (!dataQ[3]) addr <= wrap_addr(addr, dataQ[2]);
            I_FUNC:  begin eight_bit <= dataQ[4]; two_line <= dataQ[3]; end
            I_CGRAM: cgMode <= 1'b1;
            I_DDRAM: begin cgMode <= 1'b0; addr <= fold_addr(dataQ[6:0]); end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef LCD_RESP_READ_EN
  always_ff @(posedge clk) begin
    if (rst)                       rd_data <= '0;
    else if (fall && rwQ && !rsQ)  rd_data <= {busy, addr};
  end
`else
  assign rd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (memWe) mem[memWa] <= memWd;
  end

  // Read port takes a DDRAM address (same form as addr), not a raw index.
  assign rIdx = ddram_idx(mem_raddr);
  always_ff @(posedge clk) begin
    mem_rdata <= (rIdx < 7'(DDRAM_SIZE)) ? mem[rIdx] : BLANK;
  end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench with a line/column model of the display for the HD44780 responder.
module tb_lcd_hd44780_responder;
  localparam int CMD = 20;
  localparam int CLR = 200;

  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] data = 8'h00;
  logic [6:0] mem_raddr = 7'h00;
  logic [7:0] rd_data, char_wr_data, mem_rdata;
  logic       busy, display_on, cursor_on, blink_on, eight_bit, two_line;
  logic       incr, shift, char_wr, overrun;
  logic [6:0] addr, char_wr_addr;

  lcd_hd44780_responder #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .rw(rw), .data(data),
    .rd_data(rd_data), .busy(busy), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .eight_bit(eight_bit),
    .two_line(two_line), .incr(incr), .shift(shift), .addr(addr),
    .char_wr(char_wr), .char_wr_addr(char_wr_addr), .char_wr_data(char_wr_data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, printed = 0;
  logic mDisp, mCur, mBlink, mEight, mTwo, mIncr, mShift, mOvr, mCg;
  logic [6:0]  mAddr;
  logic [7:0]  mDd [80];
  logic [14:0] expWr [$];
  bit checkOn = 0;
  int busyRun = 0, lastBusyLen = 0, busyEnds = 0;

  task automatic report(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Display as two lines of 40 columns; a line is at 0x00 or 0x40.
  function automatic int idxOf(input logic [6:0] a);
    return (a[6] ? 40 : 0) + int'(a[5:0]);
  endfunction

  function automatic logic [6:0] mStep(input logic [6:0] a, input bit up);
    int line, pos;
    line = a[6] ? 1 : 0;
    pos  = int'(a[5:0]) + (up ? 1 : -1);
    if (pos == 40) begin pos = 0;  line = 1 - line; end
    if (pos < 0)   begin pos = 39; line = 1 - line; end
    return 7'(line * 64 + pos);
  endfunction

  task automatic modelReset();
    mDisp = 0; mCur = 0; mBlink = 0; mEight = 1; mTwo = 0; mIncr = 1; mShift = 0;
    mOvr = 0; mCg = 0; mAddr = 0;
    for (int i = 0; i < 80; i++) mDd[i] = 8'h20;
  endtask

  task automatic modelApply(input bit rsV, input logic [7:0] d, output int len);
    logic [6:0] a;
    len = CMD;
    if (rsV) begin
      if (!mCg) begin
        expWr.push_back({mAddr, d});
        mDd[idxOf(mAddr)] = d;
        mAddr = mStep(mAddr, mIncr);
      end
    end else if (d >= 8'h80) begin
      a = d[6:0];
      if (int'(a[5:0]) >= 40) a = a[6] ? 7'h00 : 7'h40;
      mAddr = a; mCg = 0;
    end else if (d >= 8'h40) mCg = 1;
    else if (d >= 8'h20) begin mEight = d[4]; mTwo = d[3]; end
    else if (d >= 8'h10) begin if (!d[3]) mAddr = mStep(mAddr, d[2]); end
    else if (d >= 8'h08) begin mDisp = d[2]; mCur = d[1]; mBlink = d[0]; end
    else if (d >= 8'h04) begin mIncr = d[1]; mShift = d[0]; end
    else if (d >= 8'h02) begin mAddr = 0; len = CLR; end
    else if (d == 8'h01) begin
      mAddr = 0; mIncr = 1; len = CLR;
      for (int i = 0; i < 80; i++) mDd[i] = 8'h20;
    end
  endtask

  // Continuous check of the idle-state outputs against the model.
  always @(negedge clk) begin
    if (checkOn && !busy) begin
      tests++;
      if ({display_on, cursor_on, blink_on, eight_bit, two_line, incr, shift, addr, overrun} !==
          {mDisp, mCur, mBlink, mEight, mTwo, mIncr, mShift, mAddr, mOvr}) begin
        fails++;
        if (printed < 20)
          $display("FAIL idle_state: got %b/%02h/%b, expected %b/%02h/%b at %0t",
                   {display_on, cursor_on, blink_on, eight_bit, two_line, incr, shift}, addr, overrun,
                   {mDisp, mCur, mBlink, mEight, mTwo, mIncr, mShift}, mAddr, mOvr, $time);
        printed++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && char_wr) begin
      tests++;
      if (expWr.size() == 0) begin
        fails++;
        $display("FAIL char_wr: got %02h@%02h, expected no store at %0t", char_wr_data, char_wr_addr, $time);
      end else begin
        if ({char_wr_addr, char_wr_data} !== expWr[0]) begin
          fails++;
          $display("FAIL char_wr: got %02h@%02h, expected %02h@%02h", char_wr_data, char_wr_addr,
                   expWr[0][7:0], expWr[0][14:8]);
        end
        void'(expWr.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst) busyRun = 0;
    else if (busy) busyRun++;
    else if (busyRun > 0) begin lastBusyLen = busyRun; busyRun = 0; busyEnds++; end
  end

  task automatic pulse(input bit rsV, input bit rwV, input logic [7:0] d);
    checkOn = 0;
    @(posedge clk); #1;
    rs = rsV; rw = rwV; data = d; en = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic waitEnds(input int e0, input string nm);
    int n = 0;
    while (busyEnds == e0 && n < CLR + 100) begin @(negedge clk); n++; end
    report({nm, "_busy_end"}, int'(busyEnds != e0), 1);
  endtask

  task automatic waitRise(input string nm);
    int n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    report({nm, "_busy_rise"}, int'(busy), 1);
  endtask

  task automatic cmd(input bit rsV, input logic [7:0] d, input string nm);
    int e0, len;
    e0 = busyEnds;
    pulse(rsV, 1'b0, d);
    modelApply(rsV, d, len);
    waitEnds(e0, nm);
    report({nm, "_busy_len"}, lastBusyLen, len);
    checkOn = 1;
  endtask

  task automatic memDump(input string nm);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1 mem_raddr = (i < 40) ? 7'(i) : 7'(64 + i - 40);
      @(posedge clk); #1 report(nm, mem_rdata, mDd[i]);
    end
  endtask

  initial begin
    int e0, len;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    report("rst_busy", busy, 1);
    report("rst_addr", addr, 0);
    report("rst_eight_bit", eight_bit, 1);
    report("rst_incr", incr, 1);
    report("rst_display_on", display_on, 0);
    report("rst_overrun", overrun, 0);
    report("rst_char_wr", char_wr, 0);
    report("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    waitEnds(0, "init");
    report("init_busy_len", lastBusyLen, 80);
    checkOn = 1;
    memDump("init_mem");

    cmd(0, 8'h38, "func");
    cmd(0, 8'h0C, "disp");
    cmd(0, 8'h06, "entry");
    report("lit_two_line", two_line, 1);
    report("lit_display_on", display_on, 1);
    report("lit_cursor_on", cursor_on, 0);

    cmd(0, 8'hA7, "set27");
    cmd(1, 8'h41, "wrA");
    cmd(1, 8'h42, "wrB");
    report("lit_addr_41", addr, 7'h41);
    cmd(0, 8'hE7, "set67");
    cmd(1, 8'h43, "wrC");
    report("lit_addr_wrap0", addr, 7'h00);
    memDump("wr_mem");

    // Clear with a data write arriving while busy.
    e0 = busyEnds;
    pulse(0, 1'b0, 8'h01);
    modelApply(0, 8'h01, len);
    waitRise("clear");
    repeat (5) @(negedge clk);
    pulse(1, 1'b0, 8'h5A);
    mOvr = 1;
    waitEnds(e0, "clear");
    report("clear_busy_len", lastBusyLen, CLR);
    checkOn = 1;
    report("lit_overrun", overrun, 1);
    memDump("clear_mem");

    cmd(0, 8'h04, "entry_dec");
    cmd(0, 8'hC0, "set40");
    cmd(1, 8'h44, "wrD");
    report("lit_addr_27", addr, 7'h27);
    cmd(0, 8'h10, "shl");
    report("lit_addr_26", addr, 7'h26);
    cmd(0, 8'h14, "shr");
    cmd(0, 8'h18, "dshift");
    cmd(0, 8'hA8, "set28");
    report("lit_fold_40", addr, 7'h40);
    cmd(0, 8'h40, "cgram");
    cmd(1, 8'h58, "wr_cg");
    cmd(0, 8'h80, "set00");
    cmd(1, 8'h45, "wrE");
    report("lit_addr_67", addr, 7'h67);
    cmd(0, 8'h03, "home");
    cmd(0, 8'h00, "nop");
    cmd(0, 8'h0F, "disp_all");
    memDump("mix_mem");

    // Reset in the middle of an instruction restarts the init sweep.
    pulse(0, 1'b0, 8'h0C);
    waitRise("abort");
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    e0 = busyEnds;
    waitEnds(e0, "reinit");
    report("reinit_busy_len", lastBusyLen, 80);
    checkOn = 1;
    report("lit_reinit_overrun", overrun, 0);
    memDump("reinit_mem");

`ifdef LCD_RESP_READ_EN
    cmd(0, 8'h85, "set05");
    pulse(0, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    report("rd_idle", rd_data, 8'h05);
    report("rd_idle_busy", busy, 0);
    checkOn = 1;
    e0 = busyEnds;
    pulse(0, 1'b0, 8'h01);
    modelApply(0, 8'h01, len);
    waitRise("rdclr");
    repeat (5) @(negedge clk);
    pulse(0, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    report("rd_busy", rd_data, 8'h80);
    waitEnds(e0, "rdclr");
    report("rdclr_busy_len", lastBusyLen, CLR);
    checkOn = 1;
`else
    pulse(0, 1'b1, 8'h00);
    repeat (6) @(negedge clk);
    report("rd_ignored", rd_data, 0);
    report("rd_ignored_busy", busy, 0);
    checkOn = 1;
`endif
    repeat (5) @(negedge clk);
    report("wr_queue_empty", expWr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
